// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: mode encoding, the per-stage arctangent table
// (degrees, fixed point) and the accumulated gain of a 12-stage pipeline.
package cordic_pkg;

   typedef enum logic {
      MODE_ROT = 1'b0,
      MODE_VEC = 1'b1
   } cordic_mode_e;

   // Product of sqrt(1 + 2^-2i) for i = 0..11; outputs are scaled by this.
   localparam real CORDIC_K12 = 1.6467602;

   // atan(2^-i) in degrees, rounded to nearest at frac_w fractional bits.
   function automatic longint atan_deg_fixed(input int unsigned i, input int unsigned frac_w);
      real deg;
      case (i)
         0:       deg = 45.0;
         1:       deg = 26.565051177077990;
         2:       deg = 14.036243467926479;
         3:       deg = 7.125016348901798;
         4:       deg = 3.576334374997351;
         5:       deg = 1.789910608246069;
         6:       deg = 0.895173710211074;
         7:       deg = 0.447614170860553;
         8:       deg = 0.223810500368538;
         9:       deg = 0.111905677066207;
         10:      deg = 0.055952891893804;
         11:      deg = 0.027976452617004;
         12:      deg = 0.013988227142265;
         13:      deg = 0.006994113675353;
         14:      deg = 0.003497056850704;
         15:      deg = 0.001748528426980;
         // atan(t) == t to well below one LSB from here on
         default: deg = 57.29577951308232 / (2.0 ** i);
      endcase
      return longint'(deg * (2.0 ** frac_w));
   endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation; direction chosen from the angle sign
// (rotation) or the y sign (vectoring). Holds all state while en is low.
module cordic_stage
   import cordic_pkg::*;
#(
   parameter int                DATA_W = 32,
   parameter int                TAG_W  = 4,
   parameter int                SHIFT  = 0,
   parameter logic [DATA_W-1:0] ATAN   = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              in_valid,
   input  logic              in_mode,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic [DATA_W-1:0] in_x,
   input  logic [DATA_W-1:0] in_y,
   input  logic [DATA_W-1:0] in_z,
   output logic              out_valid,
   output logic              out_mode,
   output logic [TAG_W-1:0]  out_tag,
   output logic [DATA_W-1:0] out_x,
   output logic [DATA_W-1:0] out_y,
   output logic [DATA_W-1:0] out_z
);

   logic signed [DATA_W-1:0] x_sh;
   logic signed [DATA_W-1:0] y_sh;
   logic                     d_pos;
   logic [DATA_W-1:0]        x_nx;
   logic [DATA_W-1:0]        y_nx;
   logic [DATA_W-1:0]        z_nx;

   always_comb begin
      x_sh = $signed(in_x) >>> SHIFT;
      y_sh = $signed(in_y) >>> SHIFT;
      if (in_mode == MODE_VEC) d_pos = in_y[DATA_W-1];
      else                     d_pos = ~in_z[DATA_W-1];
      if (d_pos) begin
         x_nx = in_x - y_sh;
         y_nx = in_y + x_sh;
         z_nx = in_z - ATAN;
      end else begin
         x_nx = in_x + y_sh;
         y_nx = in_y - x_sh;
         z_nx = in_z + ATAN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_mode  <= 1'b0;
         out_tag   <= '0;
         out_x     <= '0;
         out_y     <= '0;
         out_z     <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         out_mode  <= in_mode;
         out_tag   <= in_tag;
         out_x     <= x_nx;
         out_y     <= y_nx;
         out_z     <= z_nx;
      end
   end

endmodule

// File: rtl/cordic_pipe_param.sv
// Pipelined CORDIC (rotation / vectoring, degrees) with one quadrant
// pre-rotation stage, STAGES micro-rotations and a global stall enable.
module cordic_pipe_param
   import cordic_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 16,
   parameter int STAGES = 12,
   parameter int TAG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_mode,
   input  logic [DATA_W-1:0] in_x,
   input  logic [DATA_W-1:0] in_y,
   input  logic [DATA_W-1:0] in_angle,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_x,
   output logic [DATA_W-1:0] out_y,
   output logic [DATA_W-1:0] out_angle,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_mode
);

   localparam logic signed [DATA_W-1:0] DEG90  = DATA_W'(longint'(90) <<< FRAC_W);
   localparam logic signed [DATA_W-1:0] DEG180 = DATA_W'(longint'(180) <<< FRAC_W);
   localparam logic signed [DATA_W-1:0] DEGM90 = -DEG90;

   logic              en;
   logic [DATA_W-1:0] pre_x, pre_y, pre_z;

   logic              pr_v, pr_m;
   logic [TAG_W-1:0]  pr_t;
   logic [DATA_W-1:0] pr_x, pr_y, pr_z;

   logic              v_q [0:STAGES-1];
   logic              m_q [0:STAGES-1];
   logic [TAG_W-1:0]  t_q [0:STAGES-1];
   logic [DATA_W-1:0] x_q [0:STAGES-1];
   logic [DATA_W-1:0] y_q [0:STAGES-1];
   logic [DATA_W-1:0] z_q [0:STAGES-1];

   assign en       = out_ready | ~out_valid;
   assign in_ready = en;

   // Fold the input into the +/-90 degree range the micro-rotations can reach.
   always_comb begin
      pre_x = in_x;
      pre_y = in_y;
      pre_z = in_angle;
      if (in_mode == MODE_VEC) begin
         if (in_x[DATA_W-1]) begin
            pre_x = '0 - in_x;
            pre_y = '0 - in_y;
            pre_z = in_y[DATA_W-1] ? in_angle - DEG180 : in_angle + DEG180;
         end
      end else if ($signed(in_angle) > DEG90) begin
         pre_x = '0 - in_x;
         pre_y = '0 - in_y;
         pre_z = in_angle - DEG180;
      end else if ($signed(in_angle) < DEGM90) begin
         pre_x = '0 - in_x;
         pre_y = '0 - in_y;
         pre_z = in_angle + DEG180;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pr_v <= 1'b0;
         pr_m <= 1'b0;
         pr_t <= '0;
         pr_x <= '0;
         pr_y <= '0;
         pr_z <= '0;
      end else if (en) begin
         pr_v <= in_valid;
         pr_m <= in_mode;
         pr_t <= in_tag;
         pr_x <= pre_x;
         pr_y <= pre_y;
         pr_z <= pre_z;
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      logic              s_v, s_m;
      logic [TAG_W-1:0]  s_t;
      logic [DATA_W-1:0] s_x, s_y, s_z;

      if (g == 0) begin : g_first
         assign s_v = pr_v;
         assign s_m = pr_m;
         assign s_t = pr_t;
         assign s_x = pr_x;
         assign s_y = pr_y;
         assign s_z = pr_z;
      end else begin : g_next
         assign s_v = v_q[g-1];
         assign s_m = m_q[g-1];
         assign s_t = t_q[g-1];
         assign s_x = x_q[g-1];
         assign s_y = y_q[g-1];
         assign s_z = z_q[g-1];
      end

      cordic_stage #(
         .DATA_W (DATA_W),
         .TAG_W  (TAG_W),
         .SHIFT  (g),
         .ATAN   (DATA_W'(atan_deg_fixed(g, FRAC_W)))
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .en        (en),
         .in_valid  (s_v),
         .in_mode   (s_m),
         .in_tag    (s_t),
         .in_x      (s_x),
         .in_y      (s_y),
         .in_z      (s_z),
         .out_valid (v_q[g]),
         .out_mode  (m_q[g]),
         .out_tag   (t_q[g]),
         .out_x     (x_q[g]),
         .out_y     (y_q[g]),
         .out_z     (z_q[g])
      );
   end

   assign out_valid = v_q[STAGES-1];
   assign out_mode  = m_q[STAGES-1];
   assign out_tag   = t_q[STAGES-1];
   assign out_x     = x_q[STAGES-1];
   assign out_y     = y_q[STAGES-1];
   assign out_angle = z_q[STAGES-1];

endmodule

// File: tb/tb_cordic_pipe_param.sv
// Directed bench for cordic_pipe_param (DATA_W=32, FRAC_W=16, STAGES=12).
module tb_cordic_pipe_param;
   import cordic_pkg::*;

   localparam int DATA_W = 32;
   localparam int FRAC_W = 16;
   localparam int STAGES = 12;
   localparam int TAG_W  = 4;
   localparam int LAT    = STAGES + 1;
   localparam int TOL_XY = 32'h80;
   localparam int TOL_Z  = 32'h800;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              in_mode = 1'b0;
   logic [DATA_W-1:0] in_x = '0;
   logic [DATA_W-1:0] in_y = '0;
   logic [DATA_W-1:0] in_angle = '0;
   logic [TAG_W-1:0]  in_tag = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [DATA_W-1:0] out_x, out_y, out_angle;
   logic [TAG_W-1:0]  out_tag;
   logic              out_mode;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cordic_pipe_param #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .STAGES (STAGES),
      .TAG_W  (TAG_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_angle  (in_angle),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_y     (out_y),
      .out_angle (out_angle),
      .out_tag   (out_tag),
      .out_mode  (out_mode)
   );

   function automatic int absdiff(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      logic signed [DATA_W-1:0] d;
      d = $signed(a - b);
      return (d < 0) ? int'(-d) : int'(d);
   endfunction

   // Presents one sample on an idle pipe and waits (bounded) for its result.
   task automatic run_single(input logic mode, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                             input logic [DATA_W-1:0] a, input logic [TAG_W-1:0] tag,
                             output int lat, output logic [DATA_W-1:0] rx, output logic [DATA_W-1:0] ry,
                             output logic [DATA_W-1:0] rz, output logic [TAG_W-1:0] rtag, output logic rmode);
      @(negedge clk);
      in_valid = 1'b1; in_mode = mode; in_x = x; in_y = y; in_angle = a; in_tag = tag;
      lat = -1; rx = '0; ry = '0; rz = '0; rtag = '0; rmode = 1'b0;
      for (int j = 1; j <= LAT + 8; j++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid) begin
            lat = j; rx = out_x; ry = out_y; rz = out_angle; rtag = out_tag; rmode = out_mode;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      in_valid = 1'b1; in_x = 32'h00010000; in_tag = 4'hA;
      repeat (3) @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      vectors++;
      if ({out_x, out_y, out_angle} !== '0) begin
         miscompares++; $display("FAIL reset_out_data: got %h %h %h want 0", out_x, out_y, out_angle);
      end
      vectors++;
      if ({out_tag, out_mode} !== '0) begin miscompares++; $display("FAIL reset_out_tag: got %h/%b want 0", out_tag, out_mode); end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      rst = 1'b0;
      in_valid = 1'b0;
      for (int j = 0; j < LAT + 2; j++) begin
         @(negedge clk);
         vectors++;
         if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_no_ghost: got out_valid %b want 0 (cycle %0d)", out_valid, j); end
      end
   endtask

   task automatic test_rotation;
      logic [DATA_W-1:0] ang [6];
      logic [DATA_W-1:0] ex [6];
      logic [DATA_W-1:0] ey [6];
      int lat;
      logic [DATA_W-1:0] rx, ry, rz;
      logic [TAG_W-1:0] rtag;
      logic rmode;
      // 30, -30, 90, -90 (no fold) and 150, -150 (folded by the pre-rotation)
      ang = '{32'h001E0000, 32'hFFE20000, 32'h005A0000, 32'hFFA60000, 32'h00960000, 32'hFF6A0000};
      ex  = '{32'h00016D1B, 32'h00016D1B, 32'h00000000, 32'h00000000, -32'sh16D1B, -32'sh16D1B};
      ey  = '{32'h0000D2CA, -32'shD2CA,   32'h0001A593, -32'sh1A593, 32'h0000D2CA, -32'shD2CA};
      for (int k = 0; k < 6; k++) begin
         run_single(1'b0, 32'h00010000, 32'h0, ang[k], 4'(k + 1), lat, rx, ry, rz, rtag, rmode);
         vectors++;
         if (lat != LAT) begin miscompares++; $display("FAIL rot%0d_latency: got %0d want %0d", k, lat, LAT); end
         vectors++;
         if (absdiff(rx, ex[k]) > TOL_XY) begin miscompares++; $display("FAIL rot%0d_x: got %h want %h", k, rx, ex[k]); end
         vectors++;
         if (absdiff(ry, ey[k]) > TOL_XY) begin miscompares++; $display("FAIL rot%0d_y: got %h want %h", k, ry, ey[k]); end
         vectors++;
         if (absdiff(rz, 32'h0) > TOL_Z) begin miscompares++; $display("FAIL rot%0d_angle: got %h want 0", k, rz); end
         vectors++;
         if (rtag !== 4'(k + 1) || rmode !== 1'b0) begin
            miscompares++; $display("FAIL rot%0d_tag: got %h/%b want %h/0", k, rtag, rmode, 4'(k + 1));
         end
      end
   endtask

   task automatic test_vectoring;
      logic [DATA_W-1:0] vx [3];
      logic [DATA_W-1:0] vy [3];
      logic [DATA_W-1:0] ey [3];
      logic [DATA_W-1:0] ez [3];
      int lat;
      logic [DATA_W-1:0] rx, ry, rz;
      logic [TAG_W-1:0] rtag;
      logic rmode;
      vx = '{32'h00030000, -32'sh30000, -32'sh30000};
      vy = '{32'h00040000, -32'sh40000, 32'h00040000};
      // 12 stages leave ~0.0167 deg of (3,4) unresolved, so y settles near +/-0x9E
      ey = '{32'h0000009E, 32'h0000009E, -32'sh9E};
      ez = '{32'h00352150, 32'h00352150 - 32'h00B40000, 32'h00B40000 - 32'h00352150};
      for (int k = 0; k < 3; k++) begin
         run_single(1'b1, vx[k], vy[k], 32'h0, 4'(k + 8), lat, rx, ry, rz, rtag, rmode);
         vectors++;
         if (lat != LAT) begin miscompares++; $display("FAIL vec%0d_latency: got %0d want %0d", k, lat, LAT); end
         vectors++;
         if (absdiff(rx, 32'h00083BE8) > TOL_XY) begin miscompares++; $display("FAIL vec%0d_mag: got %h want 00083be8", k, rx); end
         vectors++;
         if (absdiff(ry, ey[k]) > TOL_XY) begin miscompares++; $display("FAIL vec%0d_y: got %h want %h", k, ry, ey[k]); end
         vectors++;
         if (absdiff(rz, ez[k]) > TOL_Z) begin miscompares++; $display("FAIL vec%0d_angle: got %h want %h", k, rz, ez[k]); end
         vectors++;
         if (rtag !== 4'(k + 8) || rmode !== 1'b1) begin
            miscompares++; $display("FAIL vec%0d_tag: got %h/%b want %h/1", k, rtag, rmode, 4'(k + 8));
         end
      end
   endtask

   task automatic test_back_to_back;
      bit exp_v;
      int k;
      for (int j = 0; j < LAT + 23; j++) begin
         @(negedge clk);
         k = j - LAT;
         exp_v = (j >= LAT) && (k < 20);
         vectors++;
         if (out_valid !== exp_v) begin miscompares++; $display("FAIL b2b_valid: cycle %0d got %b want %b", j, out_valid, exp_v); end
         if (exp_v) begin
            vectors++;
            if (out_tag !== 4'(k % 16) || out_mode !== 1'(k % 2)) begin
               miscompares++; $display("FAIL b2b_order: cycle %0d got tag %h mode %b want %h %b", j, out_tag, out_mode, 4'(k % 16), 1'(k % 2));
            end
         end
         vectors++;
         if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready: cycle %0d got %b want 1", j, in_ready); end
         in_valid = (j < 20);
         in_tag = 4'(j % 16); in_mode = 1'(j % 2);
         in_x = 32'h00010000; in_y = '0; in_angle = '0;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_backpressure;
      localparam int N = 24;
      int next_in = 0, next_out = 0, stall_start = -1, exp_x;
      for (int it = 0; it < 100; it++) begin
         @(negedge clk);
         if (stall_start < 0 && out_valid) stall_start = it;
         out_ready = !(stall_start >= 0 && it < stall_start + 5);
         in_valid = (next_in < N);
         in_mode = 1'b0; in_tag = 4'(next_in % 16);
         in_x = 32'((next_in + 1) << 16); in_y = '0; in_angle = '0;
         #1;
         exp_x = int'(CORDIC_K12 * 65536.0 * (next_out + 1));
         if (!out_ready) begin
            vectors++;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", it, in_ready); end
            vectors++;
            if (out_valid !== 1'b1 || out_tag !== 4'(next_out % 16) || absdiff(out_x, 32'(exp_x)) > TOL_XY) begin
               miscompares++;
               $display("FAIL bp_hold: cycle %0d got v%b tag %h x %h want v1 tag %h x %h", it, out_valid, out_tag, out_x, 4'(next_out % 16), 32'(exp_x));
            end
         end
         if (out_valid && out_ready) begin
            vectors++;
            if (out_tag !== 4'(next_out % 16) || absdiff(out_x, 32'(exp_x)) > TOL_XY) begin
               miscompares++;
               $display("FAIL bp_order: result %0d got tag %h x %h want tag %h x %h", next_out, out_tag, out_x, 4'(next_out % 16), 32'(exp_x));
            end
            next_out++;
         end
         if (in_valid && in_ready) next_in++;
         if (next_out == N) break;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      vectors++;
      if (next_out != N) begin miscompares++; $display("FAIL bp_count: got %0d results want %0d", next_out, N); end
      repeat (2) @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_duplicate: got out_valid %b want 0", out_valid); end
   endtask

   task automatic test_reset_inflight;
      int seen = 0;
      for (int it = 0; it <= LAT; it++) begin
         @(negedge clk);
         if (it == LAT) begin
            vectors++;
            if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rip_pre_valid: got %b want 1", out_valid); end
         end
         in_valid = (it < 5); in_mode = 1'b0; in_tag = 4'(it + 1);
         in_x = 32'h00010000; in_y = '0; in_angle = 32'h001E0000;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_x !== '0) begin
         miscompares++; $display("FAIL rip_async: got v%b x %h want v0 x 0", out_valid, out_x);
      end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rip_in_ready: got %b want 1", in_ready); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1; in_mode = 1'b0; in_tag = 4'h9;
      in_x = 32'h00010000; in_y = '0; in_angle = 32'h001E0000;
      for (int j = 1; j <= LAT + 6; j++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid) begin
            seen++;
            vectors++;
            if (j != LAT || out_tag !== 4'h9) begin
               miscompares++; $display("FAIL rip_stale: cycle %0d got tag %h want only tag 9 at cycle %0d", j, out_tag, LAT);
            end
            vectors++;
            if (absdiff(out_x, 32'h00016D1B) > TOL_XY || absdiff(out_y, 32'h0000D2CA) > TOL_XY) begin
               miscompares++; $display("FAIL rip_value: got x %h y %h want 00016d1b 0000d2ca", out_x, out_y);
            end
         end
      end
      vectors++;
      if (seen != 1) begin miscompares++; $display("FAIL rip_count: got %0d results want 1", seen); end
   endtask

   initial begin
      test_reset;
      test_rotation;
      test_vectoring;
      test_back_to_back;
      test_backpressure;
      test_reset_inflight;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
